// File: rtl/spi_master_param.sv
// Parametrised SPI master: configurable word width, SCLK divider, CPOL/CPHA,
// bit order and number of slave selects. One frame per accepted txgo; the
// received word is presented on rxdout together with a one-cycle rxnew strobe.
module spi_master_param #(
  parameter int DATA_W    = 8,
  parameter int CLK_DIV   = 4,
  parameter bit CPOL      = 1'b0,
  parameter bit CPHA      = 1'b0,
  parameter bit LSB_FIRST = 1'b0,
  parameter int NUM_SS    = 1,
  localparam int SS_W     = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] txdin,
  input  logic [SS_W-1:0]   ss_sel,
  input  logic              txgo,
  output logic              txrdy,
  output logic [DATA_W-1:0] rxdout,
  output logic              rxnew,
  output logic              SCLK,
  output logic              MOSI,
  input  logic              MISO,
  output logic [NUM_SS-1:0] SSn
);

  localparam int HP_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EC_W = $clog2(2 * DATA_W + 1);
  localparam logic [HP_W-1:0] HP_LAST  = HP_W'(CLK_DIV - 1);
  localparam logic [EC_W-1:0] EC_TOTAL = EC_W'(2 * DATA_W);
  localparam logic [EC_W-1:0] EC_LAST_MOSI_CPHA0 = EC_W'(2 * DATA_W - 2);
  localparam logic [EC_W-1:0] EC_FIRST_MOSI_CPHA1 = EC_W'(3);
  localparam logic [SS_W:0]   SS_LIMIT = (SS_W + 1)'(NUM_SS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    SHIFT = 2'd2,
    TRAIL = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [HP_W-1:0]     hp_q, hp_d;
  logic [EC_W-1:0]     ec_q, ec_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic [NUM_SS-1:0]   ssn_q, ssn_d;
  logic                txrdy_q, txrdy_d;
  logic [DATA_W-1:0]   rxdout_q, rxdout_d;
  logic                rxnew_q, rxnew_d;

  logic                hp_end;
  logic                do_edge;
  logic [EC_W-1:0]     edge_n;
  logic                sel_ok;
  logic                sample_en;
  logic                shift_en;

  assign txrdy  = txrdy_q;
  assign rxdout = rxdout_q;
  assign rxnew  = rxnew_q;
  assign SCLK   = sclk_q;
  assign MOSI   = mosi_q;
  assign SSn    = ssn_q;

  // Next-state logic: sequencing, SCLK edge generation and shift register updates
  always_comb begin
    state_d   = state_q;
    hp_d      = hp_q;
    ec_d      = ec_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    ssn_d     = ssn_q;
    txrdy_d   = txrdy_q;
    rxdout_d  = rxdout_q;
    rxnew_d   = 1'b0;
    do_edge   = 1'b0;
    sample_en = 1'b0;
    shift_en  = 1'b0;

    hp_end = (hp_q == HP_LAST);
    edge_n = ec_q + EC_W'(1);
    sel_ok = ({1'b0, ss_sel} < SS_LIMIT);

    case (state_q)
      IDLE: begin
        if (txgo && sel_ok) begin
          state_d = LEAD;
          hp_d    = {HP_W{1'b0}};
          ec_d    = {EC_W{1'b0}};
          tx_d    = txdin;
          txrdy_d = 1'b0;
          // The first bit is on MOSI for the whole lead-in half-period.
          mosi_d  = LSB_FIRST ? txdin[0] : txdin[DATA_W-1];
          for (int i = 0; i < NUM_SS; i++) begin
            ssn_d[i] = (ss_sel != SS_W'(i));
          end
        end else begin
          state_d = IDLE;
        end
      end
      LEAD: begin
        if (hp_end) begin
          hp_d    = {HP_W{1'b0}};
          do_edge = 1'b1;
          state_d = SHIFT;
        end else begin
          hp_d = hp_q + HP_W'(1);
        end
      end
      SHIFT: begin
        if (hp_end) begin
          hp_d = {HP_W{1'b0}};
          // The final half-period ends without an edge: SCLK is already idle.
          if (ec_q == EC_TOTAL) begin
            state_d = TRAIL;
          end else begin
            do_edge = 1'b1;
          end
        end else begin
          hp_d = hp_q + HP_W'(1);
        end
      end
      TRAIL: begin
        if (hp_end) begin
          hp_d     = {HP_W{1'b0}};
          ec_d     = {EC_W{1'b0}};
          state_d  = IDLE;
          ssn_d    = {NUM_SS{1'b1}};
          txrdy_d  = 1'b1;
          rxdout_d = rx_q;
          rxnew_d  = 1'b1;
          mosi_d   = 1'b0;
        end else begin
          hp_d = hp_q + HP_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Odd edges are leading, even edges trailing; CPHA picks which one samples.
    if (do_edge) begin
      sclk_d = ~sclk_q;
      ec_d   = edge_n;
      if (CPHA) begin
        sample_en = ~edge_n[0];
        shift_en  = edge_n[0] && (edge_n >= EC_FIRST_MOSI_CPHA1);
      end else begin
        sample_en = edge_n[0];
        shift_en  = ~edge_n[0] && (edge_n <= EC_LAST_MOSI_CPHA0);
      end
      if (sample_en) begin
        if (LSB_FIRST) begin
          rx_d = {MISO, rx_q[DATA_W-1:1]};
        end else begin
          rx_d = {rx_q[DATA_W-2:0], MISO};
        end
      end else begin
        rx_d = rx_q;
      end
      if (shift_en) begin
        if (LSB_FIRST) begin
          tx_d   = {1'b0, tx_q[DATA_W-1:1]};
          mosi_d = tx_q[1];
        end else begin
          tx_d   = {tx_q[DATA_W-2:0], 1'b0};
          mosi_d = tx_q[DATA_W-2];
        end
      end else begin
        tx_d = tx_q;
      end
    end else begin
      sclk_d = sclk_q;
    end
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      hp_q     <= {HP_W{1'b0}};
      ec_q     <= {EC_W{1'b0}};
      tx_q     <= {DATA_W{1'b0}};
      rx_q     <= {DATA_W{1'b0}};
      sclk_q   <= CPOL;
      mosi_q   <= 1'b0;
      ssn_q    <= {NUM_SS{1'b1}};
      txrdy_q  <= 1'b1;
      rxdout_q <= {DATA_W{1'b0}};
      rxnew_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      hp_q     <= hp_d;
      ec_q     <= ec_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      ssn_q    <= ssn_d;
      txrdy_q  <= txrdy_d;
      rxdout_q <= rxdout_d;
      rxnew_q  <= rxnew_d;
    end
  end

endmodule
